// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: stalls the execute stage while a multi-cycle
// MUL/DIV runs, then presents the result with a one-cycle done pulse.
module muldiv_ctrl #(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_reg;
    logic [4:0]  count_reg;
    logic [1:0]  op_reg;
    logic [31:0] quo_reg;      // rs1 for multiplies, |rs1| then quotient for divides
    logic [31:0] dvsr_reg;     // rs2 for multiplies, |rs2| for divides
    logic [31:0] rem_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [31:0] result_reg;

    // Acceptance-time decode
    logic        div_signed, div_by_zero, div_overflow;
    logic [31:0] special_result, rs1_mag, rs2_mag;

    assign div_signed   = ~op[0];
    assign div_by_zero  = (rs2 == 32'h0);
    assign div_overflow = div_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign rs1_mag      = (div_signed && rs1[31]) ? -rs1 : rs1;
    assign rs2_mag      = (div_signed && rs2[31]) ? -rs2 : rs2;

    always_comb begin
        special_result = 32'hFFFF_FFFF;
        if (div_by_zero)
            special_result = op[1] ? rs1 : 32'hFFFF_FFFF;
        else if (div_overflow)
            special_result = op[1] ? 32'h0 : 32'h8000_0000;
    end

    // Multiplier: 33-bit operands, signedness chosen by the latched funct3
    logic signed [32:0] mul_a, mul_b;
    logic signed [63:0] product;
    logic [31:0]        mul_result;

    assign mul_a      = {(op_reg == 2'b01 || op_reg == 2'b10) ? quo_reg[31] : 1'b0, quo_reg};
    assign mul_b      = {(op_reg == 2'b01) ? dvsr_reg[31] : 1'b0, dvsr_reg};
    assign product    = mul_a * mul_b;
    assign mul_result = (op_reg == 2'b00) ? product[31:0] : product[63:32];

    // Restoring divider step: 33-bit partial remainder, one quotient bit per cycle
    logic [32:0] rem_shift, trial;
    logic        fits;
    logic [31:0] rem_next, quo_next, q_fix, r_fix;

    assign rem_shift = {rem_reg, quo_reg[31]};
    assign trial     = rem_shift - {1'b0, dvsr_reg};
    assign fits      = ~trial[32];
    assign rem_next  = fits ? trial[31:0] : rem_shift[31:0];
    assign quo_next  = {quo_reg[30:0], fits};
    assign q_fix     = neg_q_reg ? -quo_next : quo_next;
    assign r_fix     = neg_r_reg ? -rem_next : rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= 5'd0;
            op_reg     <= 2'b00;
            quo_reg    <= 32'h0;
            dvsr_reg   <= 32'h0;
            rem_reg    <= 32'h0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= 32'h0;
        end else begin
            done_reg <= 1'b0;
            if (flush) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: if (start) begin
                        op_reg    <= op[1:0];
                        count_reg <= 5'd0;
                        rem_reg   <= 32'h0;
                        busy_reg  <= 1'b1;
                        neg_q_reg <= div_signed && (rs1[31] ^ rs2[31]);
                        neg_r_reg <= div_signed && rs1[31];
                        if (!op[2]) begin
                            quo_reg   <= rs1;
                            dvsr_reg  <= rs2;
                            state_reg <= MUL;
                        end else if (div_by_zero || div_overflow) begin
                            result_reg <= special_result;
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            quo_reg   <= rs1_mag;
                            dvsr_reg  <= rs2_mag;
                            state_reg <= DIV;
                        end
                    end
                    MUL: begin
                        count_reg <= count_reg + 5'd1;
                        if (count_reg == 5'(MUL_LATENCY - 1)) begin
                            result_reg <= mul_result;
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end
                    end
                    DIV: begin
                        rem_reg   <= rem_next;
                        quo_reg   <= quo_next;
                        count_reg <= count_reg + 5'd1;
                        if (count_reg == 5'd31) begin
                            result_reg <= op_reg[1] ? r_fix : q_fix;
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign stall  = ~rst & ~flush & (((state_reg == IDLE) & start) | (state_reg == MUL) | (state_reg == DIV));
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the RV32M multi-cycle operations in the execute stage. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request at a time and drives a parameterised-latency pipelined multiplier or a radix-2 restoring divider (32 iterations). It holds the pipeline with `stall` until the result is ready, then presents `result` with a one-cycle `done`. It replaces ad-hoc bubble counting in the ALU and gives the hazard unit a single stall source for M-extension ops.

## Interface
Parameters:
- MUL_LATENCY, default 3: multiplier pipeline depth in cycles; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  execute stage holds an M-extension instruction; held high by the pipeline while `stall` is high
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  32  left operand; sampled only on acceptance
- rs2  in  32  right operand; sampled only on acceptance
- flush  in  1  abort the current operation (branch mispredict or trap)
- stall  out  1  combinational; freeze IF/ID/EX
- busy  out  1  registered; state != IDLE
- done  out  1  registered; one-cycle pulse, `result` valid
- result  out  32  registered; holds its value until the next `done`

## Operation
- States: IDLE, MUL, DIV, DONE.
- Acceptance in IDLE when `start & ~flush`:
  - Latch `op`, `rs1` and `rs2`. Clear the cycle counter.
  - op[2]=0 goes to MUL.
  - Division by zero, or signed overflow (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF), goes straight to DONE with the special result.
  - Any other divide goes to DIV.
- MUL:
  - Operands are extended to 33 bits: signed for MULH and for rs1 of MULHSU, zero-extended otherwise. The product is 66 bits.
  - MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32].
  - The counter increments each cycle. When counter == MUL_LATENCY-1, capture the product into `result` and go to DONE.
- DIV:
  - Divide the unsigned magnitudes. Signed ops take |rs1| and |rs2|.
  - One quotient bit per cycle, MSB first. Remainder register is 33 bits.
  - At counter == 31, apply the sign fixup: quotient is negated if the operand signs differ; remainder takes the sign of rs1. Write `result` and go to DONE.
- Special results:
  - Divide by zero: DIV and DIVU give 0xFFFFFFFF; REM and REMU give rs1.
  - Overflow: DIV gives 0x80000000; REM gives 0.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally. A `start` seen in DONE is not accepted. The pipeline advances at the end of the DONE cycle, so the next `start` is a new instruction.
- `stall` = ~flush & ((IDLE & start) | MUL | DIV). It is 0 in DONE and 0 during `rst`.
- `flush` in any state: go to IDLE next cycle. No `done` is produced and `result` is unchanged. A flush in DONE still lets that cycle's `done` stand.
- `start` dropping while in MUL or DIV without `flush` is a protocol violation. The operation completes normally anyway.
- Reset: state IDLE, counter 0, `done` 0, `busy` 0, `result` 0x00000000. Reset mid-operation discards the operation.

## Timing
- Acceptance cycle is T; `stall` is high in T.
- Multiply: `done` in T+MUL_LATENCY+1; `stall` high T..T+MUL_LATENCY. Default is T+4.
- Divide: `done` in T+33; `stall` high T..T+32.
- Zero divisor or overflow: `done` in T+1; `stall` high only in T.
- Back-to-back: the earliest next acceptance is the cycle after DONE, which is a 1-cycle gap.
- `busy` goes high in T+1 and low in the cycle after DONE or after flush.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD (-3), MUL_LATENCY=3 → `done` at T+4 with result 0xFFFFFFEB; `stall` high for exactly T..T+3.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD at T+33. REM of the same → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Zero divisor and overflow at T+1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Abort and reset:
  - Flush at T+10 of a DIV → no `done`, `busy`=0 at T+11, `result` unchanged.
  - A MUL started at T+11 completes at T+15.
  - `rst` asserted mid-MUL → all outputs at reset values the next cycle.
- Back-to-back MUL then DIV with `start` held continuously → two distinct `done` pulses at T+4 and T+38, no extra `done`.
